data_sampling_mv: RTL

//  UART RX oversampling bit sampler: per-bit majority vote over SAMPLES taps

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/data_sampling_mv_maj_vote.sv | 25 ++
 rtl/data_sampling_mv.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART RX bit sampler.
package uart_rx_pkg;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Supported ratios only, and never above what edge_cnt can index.
  function automatic logic is_legal_prescale(input logic [5:0] prescale,
                                             input int unsigned max_prescale);
    logic ok;
    ok = (prescale == PRESCALE_8) || (prescale == PRESCALE_16) || (prescale == PRESCALE_32);
    return ok && (32'(prescale) <= max_prescale);
  endfunction

  // Tap window centred on the bit midpoint; 7 bits so legal configs never wrap.
  function automatic logic [6:0] tap_lo(input logic [5:0] prescale, input int unsigned samples);
    logic [6:0] mid;
    mid = 7'(prescale >> 1) - 7'd1;
    return mid - 7'((samples - 1) / 2);
  endfunction

  function automatic logic [6:0] tap_hi(input logic [5:0] prescale, input int unsigned samples);
    logic [6:0] mid;
    mid = 7'(prescale >> 1) - 7'd1;
    return mid + 7'((samples - 1) / 2);
  endfunction

endpackage

// File: rtl/data_sampling_mv_maj_vote.sv
// Combinational majority and unanimity over N sampled taps.
module maj_vote #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] bits,
  output logic         maj,
  output logic         unanimous
);

  localparam int unsigned OW = $clog2(N + 1);

  logic [OW-1:0] ones;

  // Popcount of the tap vector.
  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + OW'(bits[i]);
    end
  end

  assign maj       = (ones > OW'(N / 2));
  assign unanimous = (ones == '0) || (ones == OW'(N));

endmodule

// File: rtl/data_sampling_mv.sv
// UART RX oversampling bit sampler: majority vote over SAMPLES taps around mid-bit.
module data_sampling_mv
  import uart_rx_pkg::*;
#(
  parameter int unsigned MAX_PRESCALE = 32,
  parameter int unsigned SAMPLES      = 3,
  localparam int unsigned EW          = $clog2(MAX_PRESCALE)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RX_IN,
  input  logic [5:0]    Prescale,
  input  logic          data_samp_en,
  input  logic [EW-1:0] edge_cnt,
  output logic          sampled_bit,
  output logic          sample_valid,
  output logic          noise_flag,
  output logic          cfg_err
);

  localparam int unsigned CW = $clog2(SAMPLES + 1);

  if (!(SAMPLES == 3 || SAMPLES == 5)) begin : g_bad_samples
    $error("data_sampling_mv: SAMPLES must be 3 or 5");
  end

  logic [SAMPLES-1:0] taps_q, taps_d;
  logic [SAMPLES-1:0] taken_q, taken_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               cfg_ok;
  logic [6:0]         lo, hi, edge_x, idx;
  logic               on_tap, is_last, dup, capture, vote;
  logic [SAMPLES-1:0] vote_vec;
  logic               maj, unanimous;

  assign cfg_ok   = is_legal_prescale(Prescale, MAX_PRESCALE);
  assign lo       = tap_lo(Prescale, SAMPLES);
  assign hi       = tap_hi(Prescale, SAMPLES);
  assign edge_x   = 7'(edge_cnt);
  assign idx      = edge_x - lo;
  assign on_tap   = cfg_ok && data_samp_en && (edge_x >= lo) && (edge_x <= hi);
  assign is_last  = on_tap && (edge_x == hi);
  // The vote sees the tap captured on this very edge.
  assign vote_vec = {taps_q[SAMPLES-2:0], RX_IN};

  // Duplicate detection for a stalled edge counter.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < SAMPLES; i++) begin
      if (idx == 7'(i)) dup = taken_q[i];
    end
  end

  assign capture = on_tap && !dup;

  // Tap collection; any break in the sequence discards the partial set.
  always_comb begin
    taps_d  = taps_q;
    taken_d = taken_q;
    cnt_d   = cnt_q;
    vote    = 1'b0;
    if (!cfg_ok || !data_samp_en || (edge_cnt == '0)) begin
      taps_d  = '0;
      taken_d = '0;
      cnt_d   = '0;
    end else if (capture) begin
      taps_d = vote_vec;
      for (int i = 0; i < SAMPLES; i++) begin
        if (idx == 7'(i)) taken_d[i] = 1'b1;
      end
      cnt_d = cnt_q + 1'b1;
      if (is_last) begin
        vote    = (cnt_q == CW'(SAMPLES - 1));
        taps_d  = '0;
        taken_d = '0;
        cnt_d   = '0;
      end
    end else if (is_last) begin
      taps_d  = '0;
      taken_d = '0;
      cnt_d   = '0;
    end
  end

  maj_vote #(
    .N(SAMPLES)
  ) u_maj_vote (
    .bits     (vote_vec),
    .maj      (maj),
    .unanimous(unanimous)
  );

  // Tap state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      taps_q  <= '0;
      taken_q <= '0;
      cnt_q   <= '0;
    end else begin
      taps_q  <= taps_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs; bit and noise hold between votes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
      noise_flag   <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err      <= !cfg_ok;
      sample_valid <= vote;
      if (vote) begin
        sampled_bit <= maj;
        noise_flag  <= !unanimous;
      end
    end
  end

endmodule
